axioma_pmem_ctrl: RTL and testbench

Parametrised program-memory controller for the AxiomaCore-328 CPU. It connects to the CPU fetch port (`program_addr` / `program_data` / `program_ready`) and adds several features to the plain zero-latency fetch path:
- configurable wait states;
- a one-entry fetch tag, so a held address does not re-read memory;
- a defined value for out-of-range fetches;
- a loader port that writes program words at run time while CPU fetch is stalled.

It sits between the CPU core and the synchronous program RAM/flash array.

---
 rtl/axioma_pmem_ctrl.sv | 68 ++++++
 tb/tb_axioma_pmem_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/axioma_pmem_ctrl.sv
// axioma_pmem_ctrl: program-memory controller with wait states, fetch tag, out-of-range default and run-time loader
module axioma_pmem_ctrl #(
    parameter int          ADDR_WIDTH  = 14,
    parameter int          DEPTH       = 16384,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] OOR_DATA    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] program_addr,
    output logic [15:0] program_data,
    output logic        program_ready,
    input  logic        load_en,
    input  logic        load_we,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic        load_err,
    output logic        oor_fetch,
    output logic [31:0] fetch_count
);
    localparam int          IW    = (DEPTH >= 2**ADDR_WIDTH) ? ADDR_WIDTH : $clog2(DEPTH);
    localparam logic [31:0] DW    = DEPTH;
    localparam logic [2:0]  WLOAD = WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
    typedef enum logic [1:0] {IDLE, WAIT, VALID, LOAD} state_t;
    state_t      state;
    logic [15:0] tag;
    logic        tag_valid;
    logic [2:0]  wcnt;
    logic [15:0] mem [DEPTH];
    logic        start, done, fa_oor, load_oor;
    logic [15:0] fa;
    assign program_ready = state == VALID && tag_valid && program_addr == tag;
    assign load_ready    = state == LOAD;
    assign load_oor      = {16'h0, load_addr} >= DW;
    // A fetch starts from IDLE or whenever the held tag no longer matches; load_en always wins.
    always_comb begin
        start  = !load_en && (state == IDLE || (state != LOAD && program_addr != tag));
        done   = !load_en && ((start && WAIT_STATES == 0) || (state == WAIT && program_addr == tag && wcnt == 3'd0));
        fa     = start ? program_addr : tag;
        fa_oor = {16'h0, fa} >= DW;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tag          <= 16'h0;
            tag_valid    <= 1'b0;
            wcnt         <= 3'd0;
            program_data <= 16'h0;
            oor_fetch    <= 1'b0;
            fetch_count  <= 32'd0;
            load_err     <= 1'b0;
        end else begin
            oor_fetch <= done && fa_oor;
            if (done) begin
                program_data <= fa_oor ? OOR_DATA : mem[fa[IW-1:0]];
                fetch_count  <= fetch_count + 32'(fetch_count != '1);
            end
            if (start) tag <= program_addr;
            if (state == LOAD && load_we && load_oor) load_err <= 1'b1;
            tag_valid <= done ? 1'b1 : (load_en || start) ? 1'b0 : tag_valid;
            wcnt      <= start ? WLOAD : (state == WAIT && wcnt != 3'd0) ? wcnt - 3'd1 : wcnt;
            state     <= load_en ? LOAD : done ? VALID : start ? WAIT : state == LOAD ? IDLE : state;
        end
    end
    always_ff @(posedge clk)
        if (!reset && state == LOAD && load_we && !load_oor) mem[load_addr[IW-1:0]] <= load_data;
endmodule

// File: tb/tb_axioma_pmem_ctrl.sv
// tb_axioma_pmem_ctrl: two controllers (0 and 3 wait states, 32 words) driven in lockstep against an episode-level model
module tb_axioma_pmem_ctrl;
    localparam int D = 32;
    logic        clk = 1'b0, reset = 1'b1, load_en = 1'b0, load_we = 1'b0;
    logic [15:0] program_addr = 16'h0, load_addr = 16'h0, load_data = 16'h0;
    logic [31:0] pdata;
    logic [1:0]  rdy, lrdy, lerr, oor;
    logic [63:0] fcnt;
    int          ws [2] = '{0, 3};
    logic [15:0] mdl [D];
    int unsigned cnt [2];
    bit          carry [2];
    bit          err_exp, after_load;
    logic [15:0] prev = 16'hFFFF;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    axioma_pmem_ctrl #(.ADDR_WIDTH(14), .DEPTH(D), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .program_addr(program_addr), .program_data(pdata[15:0]),
        .program_ready(rdy[0]), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_ready(lrdy[0]), .load_err(lerr[0]), .oor_fetch(oor[0]),
        .fetch_count(fcnt[31:0]));
    axioma_pmem_ctrl #(.ADDR_WIDTH(14), .DEPTH(D), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .program_addr(program_addr), .program_data(pdata[31:16]),
        .program_ready(rdy[1]), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_ready(lrdy[1]), .load_err(lerr[1]), .oor_fetch(oor[1]),
        .fetch_count(fcnt[63:32]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Hold address a for h cycles; ready is due 1+WAIT_STATES cycles in, one more right after a load.
    task automatic fetch(input logic [15:0] a, input int h);
        int   lat [2];
        bit   al;
        logic er;
        al = after_load;
        for (int k = 0; k < 2; k++) lat[k] = 1 + ws[k] + int'(al);
        after_load = 0;
        program_addr = a;
        load_en = 0;
        load_we = 0;
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                er = i >= lat[k];
                chk($sformatf("ready ws%0d a=%0d i=%0d", ws[k], a, i), 32'(rdy[k]), 32'(er));
                if (er) chk($sformatf("data ws%0d a=%0d", ws[k], a), 32'(pdata[16*k +: 16]), 32'(a < D ? mdl[a[4:0]] : 16'h0000));
                chk($sformatf("oor ws%0d a=%0d i=%0d", ws[k], a, i), 32'(oor[k]), 32'((i == 0 && carry[k]) || (i == lat[k] && a >= D)));
                chk($sformatf("count ws%0d a=%0d i=%0d", ws[k], a, i), fcnt[32*k +: 32], cnt[k] + 32'(er));
                chk($sformatf("load_ready ws%0d i=%0d", ws[k], i), 32'(lrdy[k]), 32'(al && i == 0));
                chk($sformatf("load_err ws%0d", ws[k]), 32'(lerr[k]), 32'(err_exp));
            end
            step;
        end
        for (int k = 0; k < 2; k++) begin
            cnt[k] += 32'(lat[k] <= h);
            carry[k] = a >= D && lat[k] == h;
        end
        prev = a;
    endtask

    // First load_en cycle carries a write that must be ignored (not yet in LOAD).
    task automatic load_begin;
        load_en = 1;
        load_we = 1;
        load_addr = 16'($urandom_range(0, D - 1));
        load_data = 16'($urandom);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("load_ready early ws%0d", ws[k]), 32'(lrdy[k]), 32'd0);
            chk($sformatf("oor at load ws%0d", ws[k]), 32'(oor[k]), 32'(carry[k]));
            chk($sformatf("count at load ws%0d", ws[k]), fcnt[32*k +: 32], cnt[k]);
        end
        step;
        carry = '{0, 0};
    endtask

    task automatic load_write(input logic [15:0] a, input logic [15:0] d);
        load_we = 1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("load_ready ws%0d", ws[k]), 32'(lrdy[k]), 32'd1);
            chk($sformatf("ready in load ws%0d", ws[k]), 32'(rdy[k]), 32'd0);
            chk($sformatf("load_err in load ws%0d", ws[k]), 32'(lerr[k]), 32'(err_exp));
        end
        step;
        if (a < D) mdl[a[4:0]] = d;
        else err_exp = 1;
    endtask

    task automatic load_end;
        load_en = 0;
        load_we = 0;
        after_load = 1;
    endtask

    // wr: attempt a write to word 3 in the same cycle reset is asserted; it must be dropped.
    task automatic do_reset(input bit wr);
        reset = 1;
        load_en = wr;
        load_we = wr;
        load_addr = 16'd3;
        load_data = ~mdl[3];
        step;
        load_en = 0;
        load_we = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst ready ws%0d", ws[k]), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst data ws%0d", ws[k]), 32'(pdata[16*k +: 16]), 32'd0);
            chk($sformatf("rst load_ready ws%0d", ws[k]), 32'(lrdy[k]), 32'd0);
            chk($sformatf("rst load_err ws%0d", ws[k]), 32'(lerr[k]), 32'd0);
            chk($sformatf("rst oor ws%0d", ws[k]), 32'(oor[k]), 32'd0);
            chk($sformatf("rst count ws%0d", ws[k]), fcnt[32*k +: 32], 32'd0);
        end
        step;
        reset = 0;
        cnt = '{0, 0};
        carry = '{0, 0};
        err_exp = 0;
        after_load = 0;
    endtask

    initial begin
        logic [15:0] a;
        do_reset(0);
        load_begin;
        load_write(16'd0, 16'hE005);
        load_write(16'd1, 16'hE013);
        load_write(16'd2, 16'h0F01);
        for (int i = 3; i < D; i++) load_write(16'(i), 16'($urandom));
        load_write(16'd32, 16'hBEEF);
        load_end;
        fetch(16'd0, 3);
        fetch(16'd1, 2);
        fetch(16'd2, 2);
        fetch(16'd1, 14);
        fetch(16'd2, 2);
        fetch(16'd5, 6);
        fetch(16'd40, 6);
        fetch(16'd6, 6);
        load_begin;
        load_write(16'd6, 16'hC000);
        load_end;
        fetch(16'd6, 8);
        fetch(16'd9, 2);
        do_reset(0);
        fetch(16'd9, 6);
        load_begin;
        do_reset(1);
        fetch(16'd3, 6);
        repeat (80) begin
            if ($urandom_range(0, 7) == 0) begin
                load_begin;
                repeat ($urandom_range(1, 3)) load_write(16'($urandom_range(0, 40)), 16'($urandom));
                load_end;
            end
            do a = 16'($urandom_range(0, 47)); while (a == prev);
            fetch(a, $urandom_range(1, 7));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
